// File: rtl/ebus_diag_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : ebus_diag_seq_if
// Brief    : Request/response and EBUS diag-cycle signal bundle for ebus_diag_seq.
// Revision : 1.0 - initial release
// ============================================================================
interface ebus_diag_seq_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [6:0]  req_func;
    logic [35:0] req_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_write;
    logic [35:0] rsp_data;
    logic [35:0] ebus_data;
    logic [6:0]  ebus_ds;
    logic        ebus_diag_strobe;
    logic        ebus_diag_read;
    logic        drv_driving;
    logic [35:0] drv_data;

    // Sequencer side
    modport slave (
        input  req_valid, req_write, req_func, req_data, rsp_ready, ebus_data,
        output req_ready, rsp_valid, rsp_write, rsp_data,
               ebus_ds, ebus_diag_strobe, ebus_diag_read, drv_driving, drv_data
    );

    // Requester / EBUS side
    modport master (
        output req_valid, req_write, req_func, req_data, rsp_ready, ebus_data,
        input  req_ready, rsp_valid, rsp_write, rsp_data,
               ebus_ds, ebus_diag_strobe, ebus_diag_read, drv_driving, drv_data
    );
endinterface
`default_nettype wire

// File: rtl/ebus_diag_seq.sv
`default_nettype none
// ============================================================================
// Module   : ebus_diag_seq
// Brief    : Front-end EBUS diag-cycle sequencer: turns single read/write
//            requests into timed select/strobe/sample cycles on EBUS.
// Revision : 1.0 - initial release
// ============================================================================
module ebus_diag_seq #(
    parameter int SETUP_CYC     = 2,
    parameter int STROBE_CYC    = 3,
    parameter int HOLD_CYC      = 1,
    parameter int READ_WAIT_CYC = 4
) (
    input  wire logic      clk,
    input  wire logic      reset,
    ebus_diag_seq_if.slave bus
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_STROBE = 3'd2;
    localparam logic [2:0] S_HOLD   = 3'd3;
    localparam logic [2:0] S_RDWAIT = 3'd4;

    localparam logic [3:0] c_SETUP_LD  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] c_STROBE_LD = 4'(STROBE_CYC - 1);
    localparam logic [3:0] c_HOLD_LD   = 4'(HOLD_CYC - 1);
    localparam logic [3:0] c_RDWAIT_LD = 4'(READ_WAIT_CYC - 1);

    logic [2:0]  r_state;
    logic [3:0]  r_cnt;
    logic [6:0]  r_func;
    logic        r_write;
    logic [35:0] r_data;
    logic        r_rsp_valid;
    logic        r_rsp_write;
    logic [35:0] r_rsp_data;

    logic [2:0]  w_state_nxt;
    logic [3:0]  w_cnt_nxt;
    logic        w_req_ready;
    logic        w_accept;
    logic        w_rsp_set;
    logic [6:0]  w_ds;
    logic        w_strobe;
    logic        w_diag_read;
    logic        w_driving;
    logic [35:0] w_drv_data;

    // Gated by reset so nothing is accepted while reset is held.
    assign w_req_ready = ~reset & (r_state == S_IDLE) & ~r_rsp_valid;
    assign w_accept    = bus.req_valid & w_req_ready;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state: every state is loaded with N-1 and left when cnt reaches 0
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = (r_cnt == 4'd0) ? 4'd0 : r_cnt - 4'd1;
        w_rsp_set   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_SETUP;
                    w_cnt_nxt   = c_SETUP_LD;
                end
            end
            S_SETUP: begin
                if (r_cnt == 4'd0) begin
                    if (r_write) begin
                        w_state_nxt = S_STROBE;
                        w_cnt_nxt   = c_STROBE_LD;
                    end else begin
                        w_state_nxt = S_RDWAIT;
                        w_cnt_nxt   = c_RDWAIT_LD;
                    end
                end
            end
            S_STROBE: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = S_HOLD;
                    w_cnt_nxt   = c_HOLD_LD;
                end
            end
            S_HOLD, S_RDWAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = 4'd0;
                    w_rsp_set   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    // Outputs: select and data are held constant from SETUP through HOLD
    always_comb begin
        w_ds        = 7'd0;
        w_strobe    = 1'b0;
        w_diag_read = 1'b0;
        w_driving   = 1'b0;
        w_drv_data  = 36'd0;
        case (r_state)
            S_SETUP, S_STROBE, S_HOLD: begin
                w_ds        = r_func;
                w_strobe    = (r_state == S_STROBE);
                w_diag_read = ~r_write;
                w_driving   = r_write;
                w_drv_data  = r_write ? r_data : 36'd0;
            end
            S_RDWAIT: begin
                w_ds        = r_func;
                w_diag_read = 1'b1;
            end
            default: ;
        endcase
    end

    // Request latch and response holding registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_func      <= 7'd0;
            r_write     <= 1'b0;
            r_data      <= 36'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_write <= 1'b0;
            r_rsp_data  <= 36'd0;
        end else begin
            if (w_accept) begin
                r_func  <= bus.req_func;
                r_write <= bus.req_write;
                r_data  <= bus.req_data;
            end
            if (w_rsp_set) begin
                r_rsp_valid <= 1'b1;
                r_rsp_write <= r_write;
                r_rsp_data  <= r_write ? 36'd0 : bus.ebus_data;
            end else if (r_rsp_valid && bus.rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign bus.req_ready        = w_req_ready;
    assign bus.rsp_valid        = r_rsp_valid;
    assign bus.rsp_write        = r_rsp_write;
    assign bus.rsp_data         = r_rsp_data;
    assign bus.ebus_ds          = w_ds;
    assign bus.ebus_diag_strobe = w_strobe;
    assign bus.ebus_diag_read   = w_diag_read;
    assign bus.drv_driving      = w_driving;
    assign bus.drv_data         = w_drv_data;

endmodule
`default_nettype wire

// File: tb/tb_ebus_diag_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_ebus_diag_seq
// Brief    : Directed self-checking bench for ebus_diag_seq (default and all-1 timing).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ebus_diag_seq;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    ebus_diag_seq_if bus ();
    ebus_diag_seq_if bus1 ();

    ebus_diag_seq u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    ebus_diag_seq #(
        .SETUP_CYC     (1),
        .STROBE_CYC    (1),
        .HOLD_CYC      (1),
        .READ_WAIT_CYC (1)
    ) u_dut_fast (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0o expected %0o", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("ready_timeout", bus.req_ready, 1);
    endtask

    // Present a request; returns after the accepting edge (+1)
    task automatic issue(input logic wr, input logic [6:0] fn, input logic [35:0] dat);
        wait_ready();
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_func  = fn;
        bus.req_data  = dat;
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic consume();
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        check("rsp_consumed", bus.rsp_valid, 0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        bus.req_valid = 0; bus.req_write = 0; bus.req_func = 0; bus.req_data = 0;
        bus.rsp_ready = 0; bus.ebus_data = 0;
        bus1.req_valid = 0; bus1.req_write = 0; bus1.req_func = 0; bus1.req_data = 0;
        bus1.rsp_ready = 1; bus1.ebus_data = 0;
        tick();
        tick();

        // Reset state
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_ds", bus.ebus_ds, 0);
        check("rst_strobe", bus.ebus_diag_strobe, 0);
        check("rst_diag_read", bus.ebus_diag_read, 0);
        check("rst_driving", bus.drv_driving, 0);
        check("rst_drv_data", bus.drv_data, 0);
        reset = 1'b0;
        #1;
        check("rel_req_ready", bus.req_ready, 1);

        // Write: samples k=0..5 after accept edge span SETUP(2) STROBE(3) HOLD(1)
        issue(1'b1, 7'o71, 36'o123456_701234);
        for (int k = 0; k < 6; k++) begin
            check("wr_ds", bus.ebus_ds, 7'o71);
            check("wr_driving", bus.drv_driving, 1);
            check("wr_drv_data", bus.drv_data, 36'o123456_701234);
            check("wr_strobe", bus.ebus_diag_strobe, (k >= 2 && k <= 4) ? 1 : 0);
            check("wr_diag_read", bus.ebus_diag_read, 0);
            check("wr_rsp_early", bus.rsp_valid, 0);
            check("wr_busy_ready", bus.req_ready, 0);
            tick();
        end
        check("wr_rsp_valid", bus.rsp_valid, 1);
        check("wr_rsp_write", bus.rsp_write, 1);
        check("wr_rsp_data", bus.rsp_data, 0);
        check("wr_idle_ds", bus.ebus_ds, 0);
        check("wr_idle_drv", bus.drv_driving, 0);
        check("wr_idle_drv_data", bus.drv_data, 0);
        check("wr_pend_ready", bus.req_ready, 0);
        consume();
        check("wr_reopen_ready", bus.req_ready, 1);

        // Read with static EBUS data
        bus.ebus_data = 36'o777000_111222;
        issue(1'b0, 7'o40, 36'o555555_555555);
        for (int k = 0; k < 6; k++) begin
            check("rd_ds", bus.ebus_ds, 7'o40);
            check("rd_diag_read", bus.ebus_diag_read, 1);
            check("rd_driving", bus.drv_driving, 0);
            check("rd_drv_data", bus.drv_data, 0);
            check("rd_strobe", bus.ebus_diag_strobe, 0);
            check("rd_rsp_early", bus.rsp_valid, 0);
            tick();
        end
        check("rd_rsp_valid", bus.rsp_valid, 1);
        check("rd_rsp_write", bus.rsp_write, 0);
        check("rd_rsp_data", bus.rsp_data, 36'o777000_111222);
        check("rd_idle_diag_read", bus.ebus_diag_read, 0);
        consume();

        // Read: data rises to 5 in RDWAIT cycle 3 (sample k=4)
        bus.ebus_data = 36'd0;
        issue(1'b0, 7'o41, 36'd0);
        for (int k = 0; k < 6; k++) begin
            if (k == 4) bus.ebus_data = 36'o5;
            tick();
        end
        check("rd_late_data", bus.rsp_data, 36'o5);
        consume();

        // Read: data changes only in the last RDWAIT cycle (sample k=5)
        bus.ebus_data = 36'o3;
        issue(1'b0, 7'o42, 36'd0);
        for (int k = 0; k < 6; k++) begin
            if (k == 5) bus.ebus_data = 36'o7;
            tick();
        end
        check("rd_last_sample", bus.rsp_data, 36'o7);

        // Response held off: second request must wait
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_func  = 7'o12;
        bus.req_data  = 36'o1;
        bus.ebus_data = 36'o6;
        for (int k = 0; k < 10; k++) begin
            check("hold_ready", bus.req_ready, 0);
            check("hold_rsp_valid", bus.rsp_valid, 1);
            check("hold_rsp_data", bus.rsp_data, 36'o7);
            check("hold_ds", bus.ebus_ds, 0);
            tick();
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        check("hold_consumed", bus.rsp_valid, 0);
        check("hold_reopen", bus.req_ready, 1);
        check("hold_not_yet", bus.ebus_ds, 0);
        tick();
        bus.req_valid = 1'b0;
        check("hold_accept_ds", bus.ebus_ds, 7'o12);
        check("hold_accept_drv", bus.drv_data, 36'o1);
        for (int k = 0; k < 6; k++) tick();
        check("hold_wr_rsp", bus.rsp_valid, 1);
        check("hold_wr_rsp_write", bus.rsp_write, 1);
        consume();

        // Reset during STROBE aborts the cycle
        issue(1'b1, 7'o33, 36'o707070_070707);
        tick();
        tick();
        check("abort_in_strobe", bus.ebus_diag_strobe, 1);
        reset = 1'b1;
        tick();
        check("abort_strobe", bus.ebus_diag_strobe, 0);
        check("abort_driving", bus.drv_driving, 0);
        check("abort_drv_data", bus.drv_data, 0);
        check("abort_ds", bus.ebus_ds, 0);
        check("abort_rsp", bus.rsp_valid, 0);
        check("abort_ready_in_rst", bus.req_ready, 0);
        reset = 1'b0;
        #1;
        check("abort_ready_rel", bus.req_ready, 1);
        for (int k = 0; k < 6; k++) tick();
        check("abort_no_rsp", bus.rsp_valid, 0);

        // All-1 timing: write then read back-to-back, rsp_ready tied high
        bus1.ebus_data = 36'o13;
        bus1.req_valid = 1'b1;
        bus1.req_write = 1'b1;
        bus1.req_func  = 7'o21;
        bus1.req_data  = 36'o4;
        #1;
        check("f_ready0", bus1.req_ready, 1);
        tick();                                   // A0: write accepted
        bus1.req_write = 1'b0;
        bus1.req_func  = 7'o22;
        check("f_setup_ds", bus1.ebus_ds, 7'o21);
        check("f_setup_strobe", bus1.ebus_diag_strobe, 0);
        tick();                                   // A1
        check("f_strobe", bus1.ebus_diag_strobe, 1);
        tick();                                   // A2
        check("f_hold_strobe", bus1.ebus_diag_strobe, 0);
        check("f_hold_rsp", bus1.rsp_valid, 0);
        tick();                                   // A3
        check("f_wr_rsp", bus1.rsp_valid, 1);
        check("f_wr_rsp_write", bus1.rsp_write, 1);
        check("f_pend_ready", bus1.req_ready, 0);
        tick();                                   // A4: consumed
        check("f_consumed", bus1.rsp_valid, 0);
        check("f_idle_ready", bus1.req_ready, 1);
        check("f_idle_ds", bus1.ebus_ds, 0);
        tick();                                   // A5: read accepted
        bus1.req_valid = 1'b0;
        check("f_rd_ds", bus1.ebus_ds, 7'o22);
        check("f_rd_diag_read", bus1.ebus_diag_read, 1);
        tick();                                   // A6
        check("f_rd_rsp_early", bus1.rsp_valid, 0);
        check("f_rd_rdwait", bus1.ebus_diag_read, 1);
        tick();                                   // A7
        check("f_rd_rsp", bus1.rsp_valid, 1);
        check("f_rd_rsp_write", bus1.rsp_write, 0);
        check("f_rd_rsp_data", bus1.rsp_data, 36'o13);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
